// File: rtl/ddr_line_sequencer_if.sv
// Line-request bus and DDR2 command/data port bundle for ddr_line_sequencer.
// slave: the sequencer side; master: the requester plus DDR interface side.
interface ddr_line_sequencer_if;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         req_write_i;
    logic [26:0]  req_address_i;
    logic [127:0] req_data_i;
    logic         resp_valid_o;
    logic [127:0] resp_data_o;
    logic         resp_error_o;
    logic [26:0]  ddr_address_o;
    logic         ddr_write_o;
    logic         ddr_read_o;
    logic         ddr_push_o;
    logic [63:0]  ddr_write_data_o;
    logic         ddr_done_o;
    logic         ddr_ready_i;
    logic         ddr_rvalid_i;
    logic [63:0]  ddr_read_data_i;
    logic         ddr_pop_o;

    modport slave (
        input  req_valid_i, req_write_i, req_address_i, req_data_i,
        input  ddr_ready_i, ddr_rvalid_i, ddr_read_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_error_o,
        output ddr_address_o, ddr_write_o, ddr_read_o, ddr_push_o,
        output ddr_write_data_o, ddr_done_o, ddr_pop_o
    );

    modport master (
        output req_valid_i, req_write_i, req_address_i, req_data_i,
        output ddr_ready_i, ddr_rvalid_i, ddr_read_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_error_o,
        input  ddr_address_o, ddr_write_o, ddr_read_o, ddr_push_o,
        input  ddr_write_data_o, ddr_done_o, ddr_pop_o
    );
endinterface

// File: rtl/ddr_line_sequencer.sv
// DDR2 line sequencer: turns one 128-bit line request into a DDR command,
// write-data beats and a done strobe, reassembles two read beats into a line,
// and aborts any wait that exceeds TIMEOUT_CYCLES with an error response.
module ddr_line_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    ddr_line_sequencer_if.slave bus
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ST_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_RDY,
        CMD,
        PUSH_LO,
        PUSH_HI,
        DONE,
        SETTLE,
        WAIT_CMPL,
        READ_LO,
        READ_HI,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q;
    logic            wr_q;
    logic [26:0]     addr_q;
    logic [127:0]    data_q;
    logic [63:0]     lo_q;
    logic [127:0]    resp_data_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [ST_W-1:0] st_cnt_q;

    logic            accept;
    logic            in_wait;
    logic            to_expired;
    logic            timeout;
    logic            pop;
    logic            cmd_wr;
    logic            cmd_rd;
    logic            push;
    logic            done;
    logic            resp_valid;
    logic            resp_error;
    logic [26:0]     cmd_addr;
    logic [63:0]     wdata;

    // ready is a register so it reads 0 while in reset and only rises on the
    // first clock after reset release; otherwise it equals "state is IDLE".
    assign accept     = bus.req_valid_i & ready_q;
    assign in_wait    = state_q inside {WAIT_RDY, WAIT_CMPL, READ_LO, READ_HI};
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // State register and request-accept flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    // Next-state and strobe decode; a timeout overrides whatever the wait state decided.
    always_comb begin
        state_d    = state_q;
        timeout    = 1'b0;
        pop        = 1'b0;
        cmd_wr     = 1'b0;
        cmd_rd     = 1'b0;
        push       = 1'b0;
        done       = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        cmd_addr   = '0;
        wdata      = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (bus.ddr_ready_i) state_d = CMD;
                else if (to_expired) timeout = 1'b1;
            end
            CMD: begin
                cmd_wr   = wr_q;
                cmd_rd   = ~wr_q;
                cmd_addr = addr_q;
                state_d  = wr_q ? PUSH_LO : DONE;
            end
            PUSH_LO: begin
                push    = 1'b1;
                wdata   = data_q[63:0];
                state_d = PUSH_HI;
            end
            PUSH_HI: begin
                push    = 1'b1;
                wdata   = data_q[127:64];
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (st_cnt_q == ST_W'(SETTLE_CYCLES - 1)) state_d = WAIT_CMPL;
            end
            WAIT_CMPL: begin
                if (bus.ddr_ready_i) state_d = wr_q ? RESP : READ_LO;
                else if (to_expired) timeout = 1'b1;
            end
            READ_LO: begin
                if (bus.ddr_rvalid_i) begin
                    pop     = 1'b1;
                    state_d = READ_HI;
                end else if (to_expired) begin
                    timeout = 1'b1;
                end
            end
            READ_HI: begin
                if (bus.ddr_rvalid_i) begin
                    pop     = 1'b1;
                    state_d = RESP;
                end else if (to_expired) begin
                    timeout = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            resp_valid = 1'b1;
            resp_error = 1'b1;
            state_d    = IDLE;
        end
    end

    // Request latch: write flag, line-aligned address and write data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (state_q == IDLE && accept) begin
            wr_q   <= bus.req_write_i;
            addr_q <= bus.req_address_i & {{23{1'b1}}, 4'b0000};
            data_q <= bus.req_data_i;
        end
    end

    // Wait/settle counters: both restart on every state change.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q <= '0;
            st_cnt_q <= '0;
        end else if (state_d != state_q) begin
            to_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            if (in_wait) to_cnt_q <= to_cnt_q + TO_W'(1);
            if (state_q == SETTLE) st_cnt_q <= st_cnt_q + ST_W'(1);
        end
    end

    // Read-beat assembly; the response line only changes when the high beat lands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lo_q        <= '0;
            resp_data_q <= '0;
        end else if (pop) begin
            if (state_q == READ_LO) lo_q <= bus.ddr_read_data_i;
            else resp_data_q <= {bus.ddr_read_data_i, lo_q};
        end
    end

    assign bus.req_ready_o      = ready_q;
    assign bus.resp_valid_o     = resp_valid;
    assign bus.resp_error_o     = resp_error;
    assign bus.resp_data_o      = resp_data_q;
    assign bus.ddr_address_o    = cmd_addr;
    assign bus.ddr_write_o      = cmd_wr;
    assign bus.ddr_read_o       = cmd_rd;
    assign bus.ddr_push_o       = push;
    assign bus.ddr_write_data_o = wdata;
    assign bus.ddr_done_o       = done;
    assign bus.ddr_pop_o        = pop;
endmodule

// File: tb/tb_ddr_line_sequencer.sv
// Directed plus randomized bench for ddr_line_sequencer. Each transaction's
// expected event times are derived arithmetically from the request timing rules.
module tb_ddr_line_sequencer;
    localparam int SETTLE = 4;
    localparam int TMO    = 16;
    localparam int TO     = TMO - 1;

    logic clk_i = 1'b0;
    logic rst_n_i;

    ddr_line_sequencer_if ifc();

    ddr_line_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .bus    (ifc)
    );

    always #5 clk_i = ~clk_i;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_rd;

    task automatic chk(input string tag, input int w, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s w=%0d observed=%0h expected=%0h", tag, w, obs, expv);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic rdy, input int w);
        chk({tag, ":req_ready"},  w, ifc.req_ready_o, rdy);
        chk({tag, ":ddr_write"},  w, ifc.ddr_write_o, 0);
        chk({tag, ":ddr_read"},   w, ifc.ddr_read_o, 0);
        chk({tag, ":ddr_addr"},   w, ifc.ddr_address_o, 0);
        chk({tag, ":ddr_push"},   w, ifc.ddr_push_o, 0);
        chk({tag, ":ddr_wdata"},  w, ifc.ddr_write_data_o, 0);
        chk({tag, ":ddr_done"},   w, ifc.ddr_done_o, 0);
        chk({tag, ":ddr_pop"},    w, ifc.ddr_pop_o, 0);
        chk({tag, ":resp_valid"}, w, ifc.resp_valid_o, 0);
        chk({tag, ":resp_error"}, w, ifc.resp_error_o, 0);
        chk({tag, ":resp_data"},  w, ifc.resp_data_o, exp_rd);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            ifc.req_valid_i     = 1'b0;
            ifc.req_write_i     = 1'($urandom_range(1, 0));
            ifc.req_address_i   = 27'($urandom());
            ifc.req_data_i      = rnd128();
            ifc.ddr_ready_i     = 1'($urandom_range(1, 0));
            ifc.ddr_rvalid_i    = 1'b0;
            ifc.ddr_read_data_i = {$urandom(), $urandom()};
            #1;
            chk_quiet("idle", 1'b1, i);
        end
    endtask

    // Window 0 is the accept cycle; window k is k cycles later.
    // a: cycles ready stays low after accept; c: ready returns at done+1+c;
    // g1: read beat 1 arrives g1 cycles after the low-beat wait starts (may be
    // negative); g2: beat 2 gap after beat 1 pop; gaps > TO mean never.
    task automatic run_txn(input bit wr, input logic [26:0] addr, input logic [127:0] data,
                           input int a, input int c, input int g1, input int g2,
                           input logic [63:0] b1, input logic [63:0] b2,
                           input bit hold, input int rst_w);
        int t_rdy, t_cmd, t_done, t_wc, r_hi, t_exit, t_lo, q1, pop1, pop2, t_end;
        bit to, b1_on, b2_on;
        logic rdy;
        t_rdy  = 1 + a;
        t_cmd  = t_rdy + 1;
        t_done = wr ? t_cmd + 3 : t_cmd + 1;
        t_wc   = t_done + SETTLE + 1;
        r_hi   = t_done + 1 + c;
        to     = 1'b0;
        q1     = 0;
        pop1   = -1;
        pop2   = -1;
        if (r_hi - t_wc > TO) begin
            to    = 1'b1;
            t_end = t_wc + TO;
        end else begin
            t_exit = (r_hi > t_wc) ? r_hi : t_wc;
            if (wr) begin
                t_end = t_exit + 1;
            end else begin
                t_lo = t_exit + 1;
                q1   = t_lo + g1;
                if (g1 > TO) begin
                    to    = 1'b1;
                    t_end = t_lo + TO;
                end else begin
                    pop1 = (q1 > t_lo) ? q1 : t_lo;
                    if (g2 > TO) begin
                        to    = 1'b1;
                        t_end = pop1 + 1 + TO;
                    end else begin
                        pop2  = pop1 + 1 + g2;
                        t_end = pop2 + 1;
                    end
                end
            end
        end

        for (int w = 0; w <= t_end; w++) begin
            @(posedge clk_i);
            #1;
            if (w == 0) begin
                ifc.req_valid_i   = 1'b1;
                ifc.req_write_i   = wr;
                ifc.req_address_i = addr;
                ifc.req_data_i    = data;
            end else begin
                ifc.req_valid_i   = hold;
                ifc.req_write_i   = 1'($urandom_range(1, 0));
                ifc.req_address_i = 27'($urandom());
                ifc.req_data_i    = rnd128();
            end
            if (w == 0) rdy = 1'($urandom_range(1, 0));
            else if (w < t_rdy) rdy = 1'b0;
            else if (w < t_cmd) rdy = 1'b1;
            else if (w >= r_hi) rdy = 1'b1;
            else if (w < t_wc) rdy = 1'($urandom_range(1, 0));
            else rdy = 1'b0;
            ifc.ddr_ready_i  = rdy;
            b1_on            = (pop1 >= 0) && (w >= q1) && (w <= pop1);
            b2_on            = (pop2 >= 0) && (w == pop2);
            ifc.ddr_rvalid_i = b1_on || b2_on;
            ifc.ddr_read_data_i = b1_on ? b1 : b2_on ? b2 : {$urandom(), $urandom()};
            #1;
            if (w == t_end && !wr && !to) exp_rd = {b2, b1};
            chk("req_ready",  w, ifc.req_ready_o, w == 0);
            chk("ddr_write",  w, ifc.ddr_write_o, (w == t_cmd) && wr);
            chk("ddr_read",   w, ifc.ddr_read_o, (w == t_cmd) && !wr);
            chk("ddr_addr",   w, ifc.ddr_address_o, (w == t_cmd) ? {addr[26:4], 4'h0} : 27'd0);
            chk("ddr_push",   w, ifc.ddr_push_o, wr && (w == t_cmd + 1 || w == t_cmd + 2));
            chk("ddr_wdata",  w, ifc.ddr_write_data_o,
                (wr && w == t_cmd + 1) ? data[63:0] : (wr && w == t_cmd + 2) ? data[127:64] : 64'd0);
            chk("ddr_done",   w, ifc.ddr_done_o, w == t_done);
            chk("ddr_pop",    w, ifc.ddr_pop_o, (w == pop1) || (w == pop2));
            chk("resp_valid", w, ifc.resp_valid_o, w == t_end);
            chk("resp_error", w, ifc.resp_error_o, (w == t_end) && to);
            chk("resp_data",  w, ifc.resp_data_o, exp_rd);
            if (w == rst_w) begin
                #1 rst_n_i = 1'b0;
                #1 exp_rd = '0;
                chk_quiet("in_reset", 1'b0, w);
                @(posedge clk_i);
                #2 chk_quiet("in_reset", 1'b0, w + 1);
                @(negedge clk_i);
                rst_n_i          = 1'b1;
                ifc.req_valid_i  = 1'b0;
                ifc.ddr_ready_i  = 1'b0;
                ifc.ddr_rvalid_i = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        bit          r_wr, r_hold;
        int          r_a, r_c, r_g1, r_g2;
        rst_n_i             = 1'b0;
        exp_rd              = '0;
        ifc.req_valid_i     = 1'b0;
        ifc.req_write_i     = 1'b0;
        ifc.req_address_i   = '0;
        ifc.req_data_i      = '0;
        ifc.ddr_ready_i     = 1'b0;
        ifc.ddr_rvalid_i    = 1'b0;
        ifc.ddr_read_data_i = '0;
        repeat (2) @(posedge clk_i);
        #2 chk_quiet("reset", 1'b0, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle(2);

        // Write line, ready high throughout.
        run_txn(1'b1, 27'h0000123, 128'h0123_4567_89AB_CDEF_FEDC_BA98_AAAA_5555,
                0, 0, 0, 0, 64'd0, 64'd0, 1'b0, -1);
        idle(1);
        // Read line from 0x40, beats arrive once the read wait starts.
        run_txn(1'b0, 27'h40, rnd128(), 0, 1, 0, 0, 64'h1111, 64'h2222, 1'b0, -1);
        idle(1);
        // Ready held low 10 cycles at request start.
        run_txn(1'b1, 27'h1ABCDEF, rnd128(), 10, 2, 0, 0, 64'd0, 64'd0, 1'b0, -1);
        run_txn(1'b0, 27'h0000F0F, rnd128(), 10, 3, -2, 3, 64'hA5A5_0000_1234_5678, 64'h5A5A_FFFF_8765_4321, 1'b0, -1);
        // Read data never arrives: timeout in the low-beat wait, response data unchanged.
        run_txn(1'b0, 27'h0000200, rnd128(), 0, 0, 1000, 0, 64'd0, 64'd0, 1'b0, -1);
        idle(1);
        // Reset asserted during the high write beat, then a normal request.
        run_txn(1'b1, 27'h0003300, rnd128(), 0, 0, 0, 0, 64'd0, 64'd0, 1'b0, 4);
        run_txn(1'b0, 27'h0003310, rnd128(), 0, 0, 1, 1, 64'hCAFE_0001, 64'hCAFE_0002, 1'b0, -1);
        idle(1);
        // Back-to-back with valid held high.
        run_txn(1'b1, 27'h0000500, rnd128(), 0, 0, 0, 0, 64'd0, 64'd0, 1'b1, -1);
        run_txn(1'b0, 27'h0000510, rnd128(), 1, 0, 0, 0, 64'h77, 64'h88, 1'b1, -1);
        run_txn(1'b1, 27'h0000520, rnd128(), 0, 30, 0, 0, 64'd0, 64'd0, 1'b0, -1);
        idle(1);

        repeat (40) begin
            r_wr   = 1'($urandom_range(1, 0));
            r_hold = 1'($urandom_range(1, 0));
            r_a    = int'($urandom_range(5, 0));
            r_c    = ($urandom_range(9, 0) == 0) ? 40 : int'($urandom_range(8, 0));
            r_g1   = ($urandom_range(9, 0) == 0) ? 1000 : int'($urandom_range(7, 0)) - 3;
            r_g2   = ($urandom_range(9, 0) == 0) ? 1000 : int'($urandom_range(4, 0));
            run_txn(r_wr, 27'($urandom()), rnd128(), r_a, r_c, r_g1, r_g2,
                    {$urandom(), $urandom()}, {$urandom(), $urandom()}, r_hold, -1);
            if (!r_hold) idle(int'($urandom_range(2, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
